arith_cmd_sequencer: RTL and testbench

//  Issuing and consuming side of the ARITH unit interface. Accepts one operation command (A, B, FUN) over a

---
 rtl/arith_pkg.sv | 29 ++
 rtl/arith_cmd_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_arith_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the ARITH unit and its command sequencer.
// ARITH_STATUS_BYTE_EN adds the trailing status-byte state.
package arith_pkg;

  localparam int unsigned FUN_W = 2;

  typedef enum logic [FUN_W-1:0] {
    FUN_ADD = 2'b00,
    FUN_SUB = 2'b01,
    FUN_MUL = 2'b10,
    FUN_DIV = 2'b11
  } arith_fun_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND
`ifdef ARITH_STATUS_BYTE_EN
    , S_STAT
`endif
  } seq_state_e;

  // Bit positions inside the status byte {5'b0, timeout, div0, carry}
  localparam int unsigned ST_CARRY_BIT = 0;
  localparam int unsigned ST_DIV0_BIT  = 1;
  localparam int unsigned ST_TMO_BIT   = 2;

endpackage

// File: rtl/arith_cmd_sequencer.sv
// Issues one command to the ARITH unit, captures its result and streams it LSB-first as bytes.
// Define ARITH_STATUS_BYTE_EN to append a {timeout, div0, carry} status byte.
module arith_cmd_sequencer
  import arith_pkg::*;
#(
  parameter int unsigned A_width         = 16,
  parameter int unsigned B_width         = 16,
  parameter int unsigned ARITH_OUT_width = 16,
  parameter int unsigned TIMEOUT_CYC     = 15
) (
  input  logic                       CLK_CTRL,
  input  logic                       RST_CTRL,
  input  logic                       CMD_VALID,
  output logic                       CMD_READY,
  input  logic [FUN_W-1:0]           CMD_FUN,
  input  logic [A_width-1:0]         CMD_A,
  input  logic [B_width-1:0]         CMD_B,
  output logic [A_width-1:0]         A_OUT_ARITH,
  output logic [B_width-1:0]         B_OUT_ARITH,
  output logic [FUN_W-1:0]           ALU_FUN_ARITH,
  output logic                       ARITH_EN,
  input  logic [ARITH_OUT_width-1:0] ARITH_OUT_IN,
  input  logic                       ARITH_FLAG_IN,
  input  logic                       CARRY_IN,
  output logic [7:0]                 TX_DATA,
  output logic                       TX_VALID,
  input  logic                       TX_READY,
  output logic                       ERR,
  output logic                       BUSY
);

  localparam int unsigned NBYTES = ARITH_OUT_width / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

  seq_state_e                 state_q, state_d;
  logic [A_width-1:0]         a_q, a_d;
  logic [B_width-1:0]         b_q, b_d;
  logic [FUN_W-1:0]           fun_q, fun_d;
  logic                       en_q, en_d;
  logic                       err_q, err_d;
  logic [ARITH_OUT_width-1:0] res_q, res_d;
  logic [IDX_W-1:0]           idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [7:0]                 txd_q, txd_d;
  logic                       txv_q, txv_d;
  logic                       rdy_q, rdy_d;
  logic                       busy_q, busy_d;
  logic                       carry_q, carry_d;
  logic                       div0_q, div0_d;
  logic                       tmo_q, tmo_d;

  assign idx_inc = idx_q + IDX_W'(1);

`ifndef ARITH_STATUS_BYTE_EN
  // Cause flags are kept for a uniform datapath but only reach the wire in the status-byte build
  logic unused_cause;
  assign unused_cause = carry_q ^ div0_q ^ tmo_q;
`endif

  // State and datapath registers
  always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
    if (!RST_CTRL) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      carry_q <= 1'b0;
      div0_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      en_q    <= en_d;
      err_q   <= err_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      carry_q <= carry_d;
      div0_q  <= div0_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and next-output logic; the byte serializer is the idx-driven mux in SEND
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    res_d   = res_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    carry_d = carry_q;
    div0_d  = div0_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (rdy_q && CMD_VALID) begin
          a_d     = CMD_A;
          b_d     = CMD_B;
          fun_d   = CMD_FUN;
          idx_d   = '0;
          carry_d = 1'b0;
          div0_d  = 1'b0;
          tmo_d   = 1'b0;
          if (CMD_FUN == FUN_DIV && CMD_B == '0) begin
            res_d   = '1;
            div0_d  = 1'b1;
            err_d   = 1'b1;
            txd_d   = 8'hFF;
            txv_d   = 1'b1;
            state_d = S_SEND;
          end else begin
            en_d    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      // The unit clears its output after one cycle, so capture happens in the flag cycle itself
      S_WAIT: begin
        if (ARITH_FLAG_IN) begin
          res_d   = ARITH_OUT_IN;
          carry_d = CARRY_IN;
          txd_d   = ARITH_OUT_IN[7:0];
          txv_d   = 1'b1;
          state_d = S_SEND;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          txd_d   = 8'h00;
          txv_d   = 1'b1;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SEND: begin
        if (TX_READY) begin
          if (idx_q == IDX_W'(NBYTES - 1)) begin
`ifdef ARITH_STATUS_BYTE_EN
            txd_d               = '0;
            txd_d[ST_CARRY_BIT] = carry_q;
            txd_d[ST_DIV0_BIT]  = div0_q;
            txd_d[ST_TMO_BIT]   = tmo_q;
            state_d             = S_STAT;
`else
            txv_d   = 1'b0;
            state_d = S_IDLE;
`endif
          end else begin
            idx_d = idx_inc;
            txd_d = 8'(res_q >> {idx_inc, 3'b000});
          end
        end
      end

`ifdef ARITH_STATUS_BYTE_EN
      S_STAT: begin
        if (TX_READY) begin
          txv_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        txv_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  assign CMD_READY     = rdy_q;
  assign A_OUT_ARITH   = a_q;
  assign B_OUT_ARITH   = b_q;
  assign ALU_FUN_ARITH = fun_q;
  assign ARITH_EN      = en_q;
  assign TX_DATA       = txd_q;
  assign TX_VALID      = txv_q;
  assign ERR           = err_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_arith_cmd_sequencer.sv
// Directed bench for arith_cmd_sequencer with a registered ARITH unit model.
// Honors ARITH_STATUS_BYTE_EN to expect the trailing status byte.
module tb_arith_cmd_sequencer;

  localparam int unsigned TMO = 15;
`ifdef ARITH_STATUS_BYTE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        CLK_CTRL = 1'b0;
  logic        RST_CTRL = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_FUN = 2'b00;
  logic [15:0] CMD_A = '0;
  logic [15:0] CMD_B = '0;
  logic [15:0] A_OUT_ARITH;
  logic [15:0] B_OUT_ARITH;
  logic [1:0]  ALU_FUN_ARITH;
  logic        ARITH_EN;
  logic [15:0] ARITH_OUT_IN;
  logic        ARITH_FLAG_IN;
  logic        CARRY_IN;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic        ERR;
  logic        BUSY;

  int n_chk = 0;
  int n_err = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  logic unit_dead = 1'b0;
  logic [7:0] got_b [0:3];

  always #5 CLK_CTRL = ~CLK_CTRL;

  arith_cmd_sequencer #(
    .A_width(16), .B_width(16), .ARITH_OUT_width(16), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK_CTRL(CLK_CTRL), .RST_CTRL(RST_CTRL),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_FUN(CMD_FUN),
    .CMD_A(CMD_A), .CMD_B(CMD_B),
    .A_OUT_ARITH(A_OUT_ARITH), .B_OUT_ARITH(B_OUT_ARITH), .ALU_FUN_ARITH(ALU_FUN_ARITH),
    .ARITH_EN(ARITH_EN), .ARITH_OUT_IN(ARITH_OUT_IN), .ARITH_FLAG_IN(ARITH_FLAG_IN),
    .CARRY_IN(CARRY_IN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .ERR(ERR), .BUSY(BUSY)
  );

  // Registered unit: result and flag for one cycle after the enable, cleared otherwise
  always @(posedge CLK_CTRL or negedge RST_CTRL) begin
    if (!RST_CTRL) begin
      ARITH_FLAG_IN <= 1'b0;
      ARITH_OUT_IN  <= '0;
      CARRY_IN      <= 1'b0;
    end else if (ARITH_EN && !unit_dead) begin
      ARITH_FLAG_IN <= 1'b1;
      case (ALU_FUN_ARITH)
        2'b00:   {CARRY_IN, ARITH_OUT_IN} <= {1'b0, A_OUT_ARITH} + {1'b0, B_OUT_ARITH};
        2'b01:   {CARRY_IN, ARITH_OUT_IN} <= {1'b0, A_OUT_ARITH} - {1'b0, B_OUT_ARITH};
        2'b10:   {CARRY_IN, ARITH_OUT_IN} <= {1'b0, 16'(A_OUT_ARITH * B_OUT_ARITH)};
        default: {CARRY_IN, ARITH_OUT_IN} <= {1'b0, A_OUT_ARITH / B_OUT_ARITH};
      endcase
    end else begin
      ARITH_FLAG_IN <= 1'b0;
      ARITH_OUT_IN  <= '0;
      CARRY_IN      <= 1'b0;
    end
  end

  always @(negedge CLK_CTRL) begin
    if (RST_CTRL) begin
      if (ARITH_EN) en_cnt <= en_cnt + 1;
      if (ERR) err_cnt <= err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns just after the accepting clock edge
  task automatic send_cmd(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
    int cyc = 0;
    @(negedge CLK_CTRL);
    CMD_VALID = 1'b1;
    CMD_FUN   = f;
    CMD_A     = a;
    CMD_B     = b;
    while (!CMD_READY && cyc < 50) begin
      @(negedge CLK_CTRL);
      cyc++;
    end
    check("cmd_ready_seen", 32'(CMD_READY), 32'd1);
    @(posedge CLK_CTRL);
    #1 CMD_VALID = 1'b0;
  endtask

  // Collects bytes k0..n-1; lat = negedges from call to first accepted byte
  task automatic recv_bytes(input int n, input int k0, output int lat);
    int k = k0;
    int cyc = 0;
    lat = -1;
    while (k < n && cyc < 100) begin
      @(negedge CLK_CTRL);
      cyc++;
      if (TX_VALID && TX_READY) begin
        if (lat < 0) lat = cyc;
        got_b[k] = TX_DATA;
        k++;
      end
    end
    if (k < n) check("rx_bound", 32'(k), 32'(n));
  endtask

  task automatic expect_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2);
    logic [7:0] e [0:2];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int k = 0; k < NB; k++) check($sformatf("%s_byte%0d", tag, k), 32'(got_b[k]), 32'(e[k]));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge CLK_CTRL);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_ready"}, 32'(CMD_READY), 32'd1);
    check({tag, "_txv"}, 32'(TX_VALID), 32'd0);
  endtask

  initial begin
    int lat, en0, err0, cyc;

    // Reset state
    #12;
    check("rst_ready", 32'(CMD_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_txv", 32'(TX_VALID), 32'd0);
    check("rst_en", 32'(ARITH_EN), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    @(negedge CLK_CTRL);
    RST_CTRL = 1'b1;

    // 1. add 0x00FF + 0x0001 = 0x0100
    en0 = en_cnt; err0 = err_cnt;
    send_cmd(2'b00, 16'h00FF, 16'h0001);
    recv_bytes(NB, 0, lat);
    check("add_latency", 32'(lat), 32'd3);
    expect_bytes("add", 8'h00, 8'h01, 8'h00);
    check("add_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("add_err", 32'(err_cnt - err0), 32'd0);
    check("add_fun_held", 32'(ALU_FUN_ARITH), 32'd0);
    expect_idle("add");

    // 2. sub with borrow: 1 - 2
    err0 = err_cnt;
    send_cmd(2'b01, 16'h0001, 16'h0002);
    recv_bytes(NB, 0, lat);
    expect_bytes("sub", 8'hFF, 8'hFF, 8'h01);
    check("sub_err", 32'(err_cnt - err0), 32'd0);
    expect_idle("sub");

    // 3. divide by zero
    en0 = en_cnt; err0 = err_cnt;
    send_cmd(2'b11, 16'h1234, 16'h0000);
    recv_bytes(NB, 0, lat);
    check("div0_latency", 32'(lat), 32'd1);
    expect_bytes("div0", 8'hFF, 8'hFF, 8'h02);
    check("div0_en_pulses", 32'(en_cnt - en0), 32'd0);
    check("div0_err_cycles", 32'(err_cnt - err0), 32'd1);
    check("div0_b_held", 32'(B_OUT_ARITH), 32'd0);
    expect_idle("div0");

    // 4. timeout: unit never answers
    unit_dead = 1'b1;
    en0 = en_cnt; err0 = err_cnt;
    send_cmd(2'b00, 16'h0005, 16'h0006);
    recv_bytes(NB, 0, lat);
    check("tmo_latency", 32'(lat), 32'(TMO + 2));
    expect_bytes("tmo", 8'h00, 8'h00, 8'h04);
    check("tmo_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("tmo_err_cycles", 32'(err_cnt - err0), 32'd1);
    unit_dead = 1'b0;
    expect_idle("tmo");

    // 5. back-pressure on byte 0 of 0x1234 * 2
    TX_READY = 1'b0;
    send_cmd(2'b10, 16'h1234, 16'h0002);
    cyc = 0;
    while (!TX_VALID && cyc < 20) begin
      @(negedge CLK_CTRL);
      cyc++;
    end
    check("bp_valid_seen", 32'(TX_VALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_CTRL);
      check($sformatf("bp_hold%0d", i), 32'(TX_DATA), 32'h68);
      check($sformatf("bp_ready%0d", i), 32'(CMD_READY), 32'd0);
    end
    got_b[0] = TX_DATA;
    TX_READY = 1'b1;
    recv_bytes(NB, 1, lat);
    expect_bytes("bp", 8'h68, 8'h24, 8'h00);
    expect_idle("bp");

    // 6. reset while waiting on the unit, then a fresh add
    unit_dead = 1'b1;
    send_cmd(2'b00, 16'h0001, 16'h0001);
    repeat (3) @(negedge CLK_CTRL);
    check("mid_busy", 32'(BUSY), 32'd1);
    RST_CTRL = 1'b0;
    #1;
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_txv", 32'(TX_VALID), 32'd0);
    check("mid_rst_ready", 32'(CMD_READY), 32'd0);
    @(negedge CLK_CTRL);
    RST_CTRL = 1'b1;
    unit_dead = 1'b0;
    send_cmd(2'b00, 16'h0003, 16'h0004);
    recv_bytes(NB, 0, lat);
    check("rst_add_latency", 32'(lat), 32'd3);
    expect_bytes("rst_add", 8'h07, 8'h00, 8'h00);
    expect_idle("rst_add");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
